f_add: RTL and testbench

- Parameterised N-bit binary adder with carry-in and carry-out, used by the ALU arithmetic path.
- Operands and carry are captured combinationally through a grouped carry-lookahead network.
- Results are registered on the clock, giving a fixed one-cycle latency to the ALU result mux.
- Unsigned semantics; a signed-overflow flag is also produced for the ALU status logic.

---
 rtl/f_add.sv | 149 ++++++++++++++
 tb/tb_f_add.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/f_add.sv
// N-bit registered adder with carry-in/out and signed overflow, built on a
// hierarchical 4-ary carry-lookahead tree (bit -> group -> group-of-groups ...).
module f_add #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         out_valid
);

  // Node count at tree level l (level 0 = individual bits).
  function automatic int cntAt(input int l);
    int c;
    c = N;
    for (int i = 0; i < l; i++) c = (c + 3) / 4;
    return c;
  endfunction

  function automatic int offAt(input int l);
    int o;
    o = 0;
    for (int i = 0; i < l; i++) o += cntAt(i);
    return o;
  endfunction

  function automatic int numLvls();
    int l;
    l = 1;
    for (int i = 0; i < 32; i++) if (cntAt(i) > 1) l = i + 2;
    return l;
  endfunction

  localparam int LVLS = numLvls();
  localparam int TOT  = offAt(LVLS);

  // Returns {G, P} of four (g, p) pairs in two-level sum-of-products form.
  function automatic logic [1:0] grpGP(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  function automatic logic [3:0] la4Carry(input logic [3:0] g, input logic [3:0] p,
                                          input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [TOT-1:0] w_g;
  logic [TOT-1:0] w_p;
  logic [TOT-1:0] w_c;
  logic           w_cout;
  logic [N-1:0]   w_sum;
  logic           w_ovf;

  logic [N-1:0]   r_sum;
  logic           r_cout;
  logic           r_ovf;
  logic           r_valid;

  // All levels live in one flat vector; missing children of a partial group act as g=0,p=1.
  always_comb begin
    logic [3:0] w_gv;
    logic [3:0] w_pv;
    logic [3:0] w_cv;
    logic [1:0] w_gp;
    int         w_base;
    int         w_cc;
    w_g    = '0;
    w_p    = '0;
    w_c    = '0;
    w_gv   = '0;
    w_pv   = '0;
    w_cv   = '0;
    w_gp   = '0;
    w_base = 0;
    w_cc   = 0;
    w_g[N-1:0] = a & b;
    w_p[N-1:0] = a ^ b;
    for (int l = 1; l < LVLS; l++) begin
      for (int j = 0; j < N / 4; j++) begin
        if (j < cntAt(l)) begin
          w_base = offAt(l - 1) + 4 * j;
          w_cc   = cntAt(l - 1);
          for (int k = 0; k < 4; k++) begin
            w_gv[k] = (4 * j + k < w_cc) ? w_g[w_base + k] : 1'b0;
            w_pv[k] = (4 * j + k < w_cc) ? w_p[w_base + k] : 1'b1;
          end
          w_gp = grpGP(w_gv, w_pv);
          w_g[offAt(l) + j] = w_gp[1];
          w_p[offAt(l) + j] = w_gp[0];
        end
      end
    end
    w_c[TOT-1] = c_in;
    for (int l = LVLS - 1; l >= 1; l--) begin
      for (int j = 0; j < N / 4; j++) begin
        if (j < cntAt(l)) begin
          w_base = offAt(l - 1) + 4 * j;
          w_cc   = cntAt(l - 1);
          for (int k = 0; k < 4; k++) begin
            w_gv[k] = (4 * j + k < w_cc) ? w_g[w_base + k] : 1'b0;
            w_pv[k] = (4 * j + k < w_cc) ? w_p[w_base + k] : 1'b1;
          end
          w_cv = la4Carry(w_gv, w_pv, w_c[offAt(l) + j]);
          for (int k = 0; k < 4; k++) begin
            if (4 * j + k < w_cc) w_c[w_base + k] = w_cv[k];
          end
        end
      end
    end
    w_cout = w_g[TOT-1] | (w_p[TOT-1] & c_in);
  end

  assign w_sum = w_p[N-1:0] ^ w_c[N-1:0];
  assign w_ovf = w_c[N-1] ^ w_cout;

  // Data registers load every cycle; only out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_sum   <= w_sum;
      r_cout  <= w_cout;
      r_ovf   <= w_ovf;
      r_valid <= in_valid;
    end
  end

  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_f_add.sv
// Scoreboard bench for f_add at N=64 (directed, hand-computed) with N=8 and N=4
// copies fed from the low operand bits and checked against a reference model.
module tb_f_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;

  logic [63:0] sum64;
  logic        cOut64, ovf64, outValid64;
  logic [7:0]  sum8;
  logic        cOut8, ovf8, outValid8;
  logic [3:0]  sum4;
  logic        cOut4, ovf4, outValid4;

  typedef struct {
    logic        v;
    logic [63:0] s64;
    logic        c64;
    logic        o64;
    logic [63:0] s8;
    logic        c8;
    logic        o8;
    logic [63:0] s4;
    logic        c4;
    logic        o4;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;

  f_add #(.N(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .sum(sum64), .c_out(cOut64), .ovf(ovf64), .out_valid(outValid64)
  );

  f_add #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
    .sum(sum8), .c_out(cOut8), .ovf(ovf8), .out_valid(outValid8)
  );

  f_add #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]), .c_in(c_in),
    .sum(sum4), .c_out(cOut4), .ovf(ovf4), .out_valid(outValid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {ovf, c_out, sum} for width w; overflow from operand/result signs.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input int w);
    logic [64:0] m;
    logic [64:0] t;
    logic [63:0] s;
    logic        co;
    logic        ov;
    m  = (65'd1 << w) - 65'd1;
    t  = ({1'b0, x} & m) + ({1'b0, y} & m) + {64'd0, ci};
    co = t[w];
    s  = t[63:0] & m[63:0];
    ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ov, co, s};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drives one vector at the falling edge and queues its expected response.
  task automatic applyStimulus(input logic [63:0] ta, input logic [63:0] tb2, input logic tc,
                               input logic tv, input logic [63:0] es, input logic ec,
                               input logic eo);
    exp_t        e;
    logic [65:0] r;
    @(negedge clk);
    a        = ta;
    b        = tb2;
    c_in     = tc;
    in_valid = tv;
    e.v   = tv;
    e.s64 = es;
    e.c64 = ec;
    e.o64 = eo;
    r     = model(ta, tb2, tc, 8);
    e.s8  = r[63:0];
    e.c8  = r[64];
    e.o8  = r[65];
    r     = model(ta, tb2, tc, 4);
    e.s4  = r[63:0];
    e.c4  = r[64];
    e.o4  = r[65];
    expQ.push_back(e);
  endtask

  task automatic applyRandom(input logic [63:0] ta, input logic [63:0] tb2, input logic tc,
                             input logic tv);
    logic [65:0] r;
    r = model(ta, tb2, tc, 64);
    applyStimulus(ta, tb2, tc, tv, r[63:0], r[64], r[65]);
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, "_sum64"}, sum64, 64'd0);
    checkOutput({tag, "_cout64"}, {63'd0, cOut64}, 64'd0);
    checkOutput({tag, "_ovf64"}, {63'd0, ovf64}, 64'd0);
    checkOutput({tag, "_valid64"}, {63'd0, outValid64}, 64'd0);
    checkOutput({tag, "_sum8"}, {56'd0, sum8}, 64'd0);
    checkOutput({tag, "_valid8"}, {63'd0, outValid8}, 64'd0);
    checkOutput({tag, "_sum4"}, {60'd0, sum4}, 64'd0);
    checkOutput({tag, "_valid4"}, {63'd0, outValid4}, 64'd0);
  endtask

  // Monitor: one registered result per rising edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        monE = expQ.pop_front();
        checkOutput("valid64", {63'd0, outValid64}, {63'd0, monE.v});
        checkOutput("sum64", sum64, monE.s64);
        checkOutput("cout64", {63'd0, cOut64}, {63'd0, monE.c64});
        checkOutput("ovf64", {63'd0, ovf64}, {63'd0, monE.o64});
        checkOutput("valid8", {63'd0, outValid8}, {63'd0, monE.v});
        checkOutput("sum8", {56'd0, sum8}, monE.s8);
        checkOutput("cout8", {63'd0, cOut8}, {63'd0, monE.c8});
        checkOutput("ovf8", {63'd0, ovf8}, {63'd0, monE.o8});
        checkOutput("valid4", {63'd0, outValid4}, {63'd0, monE.v});
        checkOutput("sum4", {60'd0, sum4}, monE.s4);
        checkOutput("cout4", {63'd0, cOut4}, {63'd0, monE.c4});
        checkOutput("ovf4", {63'd0, ovf4}, {63'd0, monE.o4});
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    c_in     = 1'b0;
    #1 rst_n = 1'b0;

    // Inputs toggle while held in reset; outputs must stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      c_in     = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      #1;
      checkAllClear("reset");
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    applyStimulus(64'd1, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0, 1'b0);

    applyStimulus(64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0);
    applyStimulus(64'h1, 64'h1, 1'b0, 1'b1, 64'h2, 1'b0, 1'b0);
    applyStimulus(64'h1, 64'h11, 1'b0, 1'b1, 64'h12, 1'b0, 1'b0);
    applyStimulus(64'h11, 64'h11, 1'b0, 1'b1, 64'h22, 1'b0, 1'b0);

    applyStimulus(64'h0101010101010101, 64'h0010101010101011, 1'b0, 1'b1,
                  64'h0111111111111112, 1'b0, 1'b0);
    applyStimulus(64'h1111111111111111, 64'h1111111111111111, 1'b0, 1'b1,
                  64'h2222222222222222, 1'b0, 1'b0);

    applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1,
                  64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0);
    applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0);
    applyStimulus(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b1,
                  64'h8000000000000000, 1'b0, 1'b1);
    applyStimulus(64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b1,
                  64'h0, 1'b1, 1'b1);

    applyStimulus(64'h5, 64'h3, 1'b1, 1'b1, 64'h9, 1'b0, 1'b0);
    applyStimulus(64'hA, 64'h6, 1'b0, 1'b0, 64'h10, 1'b0, 1'b0);
    applyStimulus(64'hF0, 64'h0F, 1'b1, 1'b1, 64'h100, 1'b0, 1'b0);

    // Reset between edges with a result pending: outputs must clear before the next edge.
    applyStimulus(64'h1234, 64'h4321, 1'b0, 1'b1, 64'h5555, 1'b0, 1'b0);
    @(negedge clk);
    a        = 64'hFFFFFFFFFFFFFFFF;
    b        = 64'h1;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkAllClear("midreset");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 7 == 0) ra = ~rb;
      applyRandom(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("drain", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
